ingress_dispatch: RTL and testbench



---
 rtl/ingress_dispatch_pkg.sv | 18 +
 rtl/ingress_skid.sv | 62 ++++++
 rtl/ingress_dispatch.sv | 142 ++++++++++++++
 tb/tb_ingress_dispatch.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ingress_dispatch_pkg.sv
// Shared constants and state type for the ingress dispatcher that feeds the
// four-lane FIFO/arbiter switch.
package ingress_dispatch_pkg;

  localparam int unsigned DATA_W    = 10;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned NUM_LANES = 4;
  // Lane select is the top LANE_W bits of each word.
  localparam int unsigned LANE_W    = 2;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

endpackage

// File: rtl/ingress_skid.sv
// Two-entry in-order holding buffer between the upstream handshake and lane
// dispatch; entry 0 is always the head.
module ingress_skid
  import ingress_dispatch_pkg::*;
#(
  parameter int unsigned data_width = DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [data_width-1:0] wr_data,
  input  logic                  rd_en,
  output logic [data_width-1:0] head,
  output logic [1:0]            count
);

  logic [data_width-1:0] slot0;
  logic [data_width-1:0] slot1;
  logic [1:0]            cnt;
  logic                  rd_ok;
  logic                  wr_ok;

  assign rd_ok = rd_en && (cnt != 2'd0);
  // A write into a full buffer is only safe when the head leaves this cycle.
  assign wr_ok = wr_en && ((cnt != 2'd2) || rd_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10: begin
          if (cnt == 2'd0) slot0 <= wr_data;
          else             slot1 <= wr_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            slot0 <= wr_data;
          end else begin
            slot0 <= slot1;
            slot1 <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = slot0;
  assign count = cnt;

endmodule

// File: rtl/ingress_dispatch.sv
// Steers a single valid/ready word stream onto the switch's four input lanes by
// class bits, honouring per-lane pause and keeping per-lane push counters.
module ingress_dispatch
  import ingress_dispatch_pkg::*;
#(
  parameter int unsigned data_width = DATA_W,
  parameter int unsigned cnt_width  = CNT_W,
  parameter int unsigned skid_depth = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [data_width-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            pause,
  output logic [data_width-1:0] FIFO_data_in0,
  output logic [data_width-1:0] FIFO_data_in1,
  output logic [data_width-1:0] FIFO_data_in2,
  output logic [data_width-1:0] FIFO_data_in3,
  output logic                  push0,
  output logic                  push1,
  output logic                  push2,
  output logic                  push3,
  input  logic [1:0]            idx,
  input  logic                  req,
  output logic [cnt_width-1:0]  cnt_out,
  output logic                  cnt_valid,
  output logic                  IDLE
);

  localparam logic [1:0] SKID_FULL = 2'(skid_depth);

  state_t                 state;
  state_t                 state_next;
  logic [1:0]             count;
  logic [1:0]             count_next;
  logic [data_width-1:0]  head;
  logic [LANE_W-1:0]      lane;
  logic [NUM_LANES-1:0]   lane_sel;
  logic                   accept;
  logic                   dispatch;

  logic [NUM_LANES-1:0]   push_q;
  logic [data_width-1:0]  fifo_data [NUM_LANES];
  logic [cnt_width-1:0]   lane_cnt  [NUM_LANES];

  assign accept   = in_valid && in_ready;
  assign lane     = head[data_width-1 -: LANE_W];
  assign lane_sel = NUM_LANES'(1) << lane;
  assign dispatch = (count != 2'd0) && !pause[lane] && !init;

  ingress_skid #(
    .data_width (data_width)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .flush   (init),
    .wr_en   (accept),
    .wr_data (in_data),
    .rd_en   (dispatch),
    .head    (head),
    .count   (count)
  );

  // Mirror of the skid occupancy after this edge, so in_ready can be registered.
  always_comb begin
    count_next = count;
    if (init) begin
      count_next = '0;
    end else begin
      case ({accept, dispatch})
        2'b10:   count_next = count + 2'd1;
        2'b01:   count_next = count - 2'd1;
        default: count_next = count;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RESET:  state_next = init ? ST_INIT : ST_IDLE;
      ST_INIT:   state_next = init ? ST_INIT : ST_IDLE;
      ST_IDLE: begin
        if (init)          state_next = ST_INIT;
        else if (in_valid) state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)                                   state_next = ST_INIT;
        else if ((count_next == 2'd0) && !in_valid) state_next = ST_IDLE;
      end
      default:   state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RESET;
      in_ready <= 1'b0;
    end else begin
      state    <= state_next;
      in_ready <= ((state_next == ST_IDLE) || (state_next == ST_ACTIVE)) &&
                  (count_next < SKID_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      push_q    <= '0;
      cnt_out   <= '0;
      cnt_valid <= 1'b0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        fifo_data[i] <= '0;
        lane_cnt[i]  <= '0;
      end
    end else begin
      push_q    <= dispatch ? lane_sel : '0;
      cnt_valid <= req;
      // Sampled before this edge's increment, so a same-lane push reports the old value.
      if (req) cnt_out <= lane_cnt[idx];
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        if (dispatch && lane_sel[i]) fifo_data[i] <= head;
        if (init)                            lane_cnt[i] <= '0;
        else if (dispatch && lane_sel[i])    lane_cnt[i] <= lane_cnt[i] + 1'b1;
      end
    end
  end

  assign push0 = push_q[0];
  assign push1 = push_q[1];
  assign push2 = push_q[2];
  assign push3 = push_q[3];

  assign FIFO_data_in0 = fifo_data[0];
  assign FIFO_data_in1 = fifo_data[1];
  assign FIFO_data_in2 = fifo_data[2];
  assign FIFO_data_in3 = fifo_data[3];

  assign IDLE = (state == ST_IDLE);

endmodule

// File: tb/tb_ingress_dispatch.sv
// Self-checking bench for ingress_dispatch: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_ingress_dispatch;

  logic       clk = 1'b0;
  logic       reset, init, in_valid, in_ready, req, cnt_valid, IDLE;
  logic [9:0] in_data;
  logic [3:0] pause;
  logic [1:0] idx;
  logic [4:0] cnt_out;
  logic [9:0] FIFO_data_in0, FIFO_data_in1, FIFO_data_in2, FIFO_data_in3;
  logic       push0, push1, push2, push3;

  always #5 clk = ~clk;

  ingress_dispatch #(
    .data_width (10),
    .cnt_width  (5),
    .skid_depth (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .init          (init),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .pause         (pause),
    .FIFO_data_in0 (FIFO_data_in0),
    .FIFO_data_in1 (FIFO_data_in1),
    .FIFO_data_in2 (FIFO_data_in2),
    .FIFO_data_in3 (FIFO_data_in3),
    .push0         (push0),
    .push1         (push1),
    .push2         (push2),
    .push3         (push3),
    .idx           (idx),
    .req           (req),
    .cnt_out       (cnt_out),
    .cnt_valid     (cnt_valid),
    .IDLE          (IDLE)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: words waiting in order, plain integer lane counts.
  localparam int PH_RESET = 0, PH_INIT = 1, PH_IDLE = 2, PH_ACTIVE = 3;
  logic [9:0]  mq[$];
  int unsigned mcnt [4];
  logic [9:0]  m_data [4];
  logic [3:0]  m_push;
  logic        m_ready, m_idle, m_cvalid, m_accepted;
  logic [4:0]  m_cout;
  int          m_phase;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [9:0] w;
    int unsigned ln;
    m_accepted = in_valid && m_ready && !reset;
    if (reset) begin
      mq.delete();
      for (int i = 0; i < 4; i++) begin mcnt[i] = 0; m_data[i] = '0; end
      m_push = '0; m_ready = 1'b0; m_idle = 1'b0; m_cvalid = 1'b0; m_cout = '0;
      m_phase = PH_RESET;
      return;
    end
    m_push   = '0;
    m_cvalid = req;
    if (req) m_cout = 5'(mcnt[idx]);
    if (!init && mq.size() > 0) begin
      w  = mq[0];
      ln = int'(w[9:8]);
      if (!pause[ln]) begin
        m_push[ln] = 1'b1;
        m_data[ln] = w;
        void'(mq.pop_front());
        mcnt[ln] = (mcnt[ln] + 1) % 32;
      end
    end
    if (init) begin
      mq.delete();
      for (int i = 0; i < 4; i++) mcnt[i] = 0;
    end else if (m_accepted) begin
      mq.push_back(in_data);
    end
    case (m_phase)
      PH_RESET, PH_INIT: m_phase = init ? PH_INIT : PH_IDLE;
      PH_IDLE:   m_phase = init ? PH_INIT : (in_valid ? PH_ACTIVE : PH_IDLE);
      default:   m_phase = init ? PH_INIT :
                           ((mq.size() == 0 && !in_valid) ? PH_IDLE : PH_ACTIVE);
    endcase
    m_ready = (m_phase == PH_IDLE || m_phase == PH_ACTIVE) && (mq.size() < 2);
    m_idle  = (m_phase == PH_IDLE);
  endtask

  task automatic compare_all();
    check("in_ready", in_ready, m_ready);
    check("push", {push3, push2, push1, push0}, m_push);
    check("data0", FIFO_data_in0, m_data[0]);
    check("data1", FIFO_data_in1, m_data[1]);
    check("data2", FIFO_data_in2, m_data[2]);
    check("data3", FIFO_data_in3, m_data[3]);
    check("IDLE", IDLE, m_idle);
    check("cnt_valid", cnt_valid, m_cvalid);
    check("cnt_out", cnt_out, m_cout);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic send(input logic [9:0] d);
    int unsigned n = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      step();
      n++;
    end while (!m_accepted && n < 64);
    check("send_bound", n < 64, 1'b1);
  endtask

  task automatic idle(input int unsigned cycles);
    in_valid = 1'b0;
    for (int unsigned i = 0; i < cycles; i++) step();
  endtask

  initial begin
    m_ready = 1'b0;
    m_phase = PH_RESET;
    reset = 1'b1; init = 1'b0; in_valid = 1'b0; in_data = '0;
    pause = '0; req = 1'b0; idx = '0;
    step();
    step();
    check("rst_ready", in_ready, 1'b0);
    check("rst_push", {push3, push2, push1, push0}, 4'b0000);
    check("rst_idle", IDLE, 1'b0);
    check("rst_cvalid", cnt_valid, 1'b0);
    reset = 1'b0;
    step();
    check("rst_to_idle", IDLE, 1'b1);

    // Lane steering, back-to-back stream.
    send(10'h005);
    send(10'h105);
    check("t1_latency", {push3, push2, push1, push0}, 4'b0001);
    send(10'h205);
    send(10'h305);
    idle(3);
    check("t1_idle", IDLE, 1'b1);
    check("t1_d0", FIFO_data_in0, 10'h005);
    check("t1_d3", FIFO_data_in3, 10'h305);

    // Backpressure with head-of-line blocking.
    pause = 4'b0010;
    send(10'h101);
    send(10'h002);
    check("t2_full_ready", in_ready, 1'b0);
    in_data = 10'h003;
    for (int i = 0; i < 3; i++) step();
    check("t2_held_push", {push3, push2, push1, push0}, 4'b0000);
    pause = 4'b0000;
    begin
      int unsigned n = 0;
      do begin step(); n++; end while (!m_accepted && n < 64);
      check("t2_release_bound", n < 64, 1'b1);
    end
    idle(4);
    check("t2_d1", FIFO_data_in1, 10'h101);
    check("t2_d0", FIFO_data_in0, 10'h003);

    // Counter wrap after 33 lane-2 pushes.
    init = 1'b1; step();
    init = 1'b0; step();
    for (int i = 0; i < 33; i++) send(10'h200 | 10'(i));
    idle(3);
    req = 1'b1; idx = 2'd2; step();
    check("t3_wrap", cnt_out, 5'd1);
    check("t3_wrap_v", cnt_valid, 1'b1);
    idx = 2'd3; step();
    check("t3_lane3", cnt_out, 5'd0);
    req = 1'b0; step();

    // Query coinciding with a lane-0 push.
    init = 1'b1; step();
    init = 1'b0; step();
    for (int i = 0; i < 7; i++) send(10'(i));
    idle(2);
    send(10'h07f);
    in_valid = 1'b0; req = 1'b1; idx = 2'd0;
    step();
    check("t4_pre_inc", cnt_out, 5'd7);
    check("t4_push", push0, 1'b1);
    step();
    check("t4_post_inc", cnt_out, 5'd8);
    req = 1'b0;

    // Init while the skid holds paused words.
    pause = 4'b0001;
    send(10'h011);
    send(10'h022);
    in_valid = 1'b0; init = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req = (i == 1);
      idx = 2'd0;
      step();
      check("t5_ready", in_ready, 1'b0);
      check("t5_push", {push3, push2, push1, push0}, 4'b0000);
    end
    check("t5_cnt0", cnt_out, 5'd0);
    init = 1'b0; req = 1'b0;
    step();
    check("t5_idle", IDLE, 1'b1);
    pause = 4'b0000;
    idle(3);
    check("t5_discard", FIFO_data_in0, 10'h07f);

    // Reset mid-stream.
    pause = 4'b0100;
    send(10'h1aa);
    send(10'h2bb);
    req = 1'b1; reset = 1'b1;
    step();
    check("t6_push", {push3, push2, push1, push0}, 4'b0000);
    check("t6_ready", in_ready, 1'b0);
    check("t6_idle", IDLE, 1'b0);
    check("t6_cvalid", cnt_valid, 1'b0);
    reset = 1'b0; req = 1'b0; in_valid = 1'b0; pause = 4'b0000;
    step();

    // Random traffic.
    for (int unsigned c = 0; c < 3000; c++) begin
      if (!(in_valid && !m_accepted)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 10'($urandom);
      end
      pause = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      req   = ($urandom_range(0, 3) == 0);
      idx   = 2'($urandom);
      init  = ($urandom_range(0, 99) == 0);
      reset = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
